// File: rtl/spy_regs.sv
// spy_regs: spy register bank and run/step/halt controller on the spy_port debug bus.
// Snapshots CPU state at instruction boundaries and drives the CPU run enable.
// Optional feature macro: SPY_BREAKPOINT_EN (adds the BREAK register at eadr 12 and PC compare).
module spy_regs #(
    parameter int PC_WIDTH     = 14,
    parameter int STEP_WIDTH   = 16,
    parameter int RUN_ON_RESET = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dbread,
    input  logic                dbwrite,
    input  logic [3:0]          eadr,
    input  logic [15:0]         db_wdata,
    output logic [15:0]         db_rdata,
    input  logic [47:0]         cpu_ir,
    input  logic [PC_WIDTH-1:0] cpu_pc,
    input  logic [31:0]         cpu_md,
    input  logic [31:0]         cpu_vma,
    input  logic                cpu_inst_done,
    output logic                cpu_run,
    output logic                cpu_reset_req
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  halt_pend_q, halt_pend_d;
    logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
    logic [STEP_WIDTH-1:0] stepcnt_q, stepcnt_d;
    logic [15:0]           scratch_q, scratch_d;
    logic [47:0]           ir_q, ir_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]           md_q, md_d;
    logic [31:0]           vma_q, vma_d;
    logic                  cpu_run_q, cpu_run_d;
    logic                  cpu_reset_req_q, cpu_reset_req_d;
    logic                  bp_hit_s;
    logic                  bp_match_s;
    logic [15:0]           break_rd_s;

    // Boundaries only count while the CPU is actually enabled.
    logic done_s;
    logic wr_ctrl_s;
    assign done_s    = cpu_inst_done & cpu_run_q;
    assign wr_ctrl_s = dbwrite & (eadr == 4'd9);

`ifdef SPY_BREAKPOINT_EN
    logic                bp_en_q, bp_en_d;
    logic [PC_WIDTH-1:0] bp_pc_q, bp_pc_d;
    logic                bp_hit_q, bp_hit_d;

    // Breakpoint register update and match against the PC at the boundary.
    always_comb begin
        bp_en_d    = bp_en_q;
        bp_pc_d    = bp_pc_q;
        break_rd_s = 16'h0000;
        break_rd_s[PC_WIDTH-1:0] = bp_pc_q;
        break_rd_s[15] = bp_en_q;
        if (dbwrite && (eadr == 4'd12)) begin
            bp_en_d = db_wdata[15];
            bp_pc_d = db_wdata[PC_WIDTH-1:0];
        end else begin
            bp_en_d = bp_en_q;
        end
        bp_match_s = bp_en_q & done_s & (state_q != ST_HALTED) & (cpu_pc == bp_pc_q);
        bp_hit_d = bp_hit_q;
        if (wr_ctrl_s) begin
            bp_hit_d = 1'b0;
        end else if (bp_match_s) begin
            bp_hit_d = 1'b1;
        end else begin
            bp_hit_d = bp_hit_q;
        end
    end

    // Breakpoint state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bp_en_q  <= 1'b0;
            bp_pc_q  <= '0;
            bp_hit_q <= 1'b0;
        end else begin
            bp_en_q  <= bp_en_d;
            bp_pc_q  <= bp_pc_d;
            bp_hit_q <= bp_hit_d;
        end
    end
    assign bp_hit_s = bp_hit_q;
`else
    assign bp_match_s = 1'b0;
    assign bp_hit_s   = 1'b0;
    assign break_rd_s = 16'h0000;
`endif

    // Controller next state, snapshot capture and register-bank writes.
    always_comb begin
        state_d         = state_q;
        halt_pend_d     = halt_pend_q;
        remaining_d     = remaining_q;
        stepcnt_d       = stepcnt_q;
        scratch_d       = scratch_q;
        ir_d            = ir_q;
        pc_d            = pc_q;
        md_d            = md_q;
        vma_d           = vma_q;
        cpu_reset_req_d = wr_ctrl_s & db_wdata[2];

        if (done_s) begin
            ir_d  = cpu_ir;
            pc_d  = cpu_pc;
            md_d  = cpu_md;
            vma_d = cpu_vma;
            case (state_q)
                ST_RUN: begin
                    if (halt_pend_q) begin
                        state_d     = ST_HALTED;
                        halt_pend_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_STEP: begin
                    if (halt_pend_q || (remaining_q <= {{(STEP_WIDTH-1){1'b0}}, 1'b1})) begin
                        state_d     = ST_HALTED;
                        halt_pend_d = 1'b0;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - {{(STEP_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: state_d = state_q;
            endcase
            if (bp_match_s) begin
                state_d     = ST_HALTED;
                halt_pend_d = 1'b0;
                remaining_d = '0;
            end else begin
                state_d = state_d;
            end
        end else begin
            state_d = state_q;
        end

        // A CONTROL write overrides whatever the boundary decided; rst alone leaves state alone.
        if (wr_ctrl_s) begin
            if (db_wdata[2]) begin
                state_d = state_d;
            end else if (db_wdata[0]) begin
                state_d     = ST_RUN;
                halt_pend_d = 1'b0;
                remaining_d = '0;
            end else if (db_wdata[1]) begin
                state_d     = ST_STEP;
                halt_pend_d = 1'b0;
                remaining_d = (stepcnt_q == '0) ? {{(STEP_WIDTH-1){1'b0}}, 1'b1} : stepcnt_q;
            end else begin
                state_d     = state_q;
                remaining_d = remaining_q;
                halt_pend_d = (state_q != ST_HALTED);
            end
        end else begin
            halt_pend_d = halt_pend_d;
        end

        if (dbwrite && (eadr == 4'd10)) begin
            stepcnt_d = db_wdata[STEP_WIDTH-1:0];
        end else if (dbwrite && (eadr == 4'd11)) begin
            scratch_d = db_wdata;
        end else begin
            stepcnt_d = stepcnt_q;
        end

        cpu_run_d = (state_d != ST_HALTED);
    end

    // Controller, snapshot and register-bank flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= (RUN_ON_RESET != 0) ? ST_RUN : ST_HALTED;
            cpu_run_q       <= (RUN_ON_RESET != 0);
            halt_pend_q     <= 1'b0;
            remaining_q     <= '0;
            stepcnt_q       <= '0;
            scratch_q       <= 16'h0000;
            ir_q            <= 48'h0;
            pc_q            <= '0;
            md_q            <= 32'h0;
            vma_q           <= 32'h0;
            cpu_reset_req_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cpu_run_q       <= cpu_run_d;
            halt_pend_q     <= halt_pend_d;
            remaining_q     <= remaining_d;
            stepcnt_q       <= stepcnt_d;
            scratch_q       <= scratch_d;
            ir_q            <= ir_d;
            pc_q            <= pc_d;
            md_q            <= md_d;
            vma_q           <= vma_d;
            cpu_reset_req_q <= cpu_reset_req_d;
        end
    end

    // Read mux: combinational from eadr so data is ready in the strobe cycle.
    always_comb begin
        logic [15:0] pc_ext;
        logic [15:0] step_ext;
        pc_ext   = 16'h0000;
        pc_ext[PC_WIDTH-1:0] = pc_q;
        step_ext = 16'h0000;
        step_ext[STEP_WIDTH-1:0] = stepcnt_q;
        case (eadr)
            4'd0:    db_rdata = ir_q[15:0];
            4'd1:    db_rdata = ir_q[31:16];
            4'd2:    db_rdata = ir_q[47:32];
            4'd3:    db_rdata = pc_ext;
            4'd4:    db_rdata = md_q[15:0];
            4'd5:    db_rdata = md_q[31:16];
            4'd6:    db_rdata = vma_q[15:0];
            4'd7:    db_rdata = vma_q[31:16];
            4'd8:    db_rdata = {13'h0, bp_hit_s, (state_q == ST_STEP), (state_q == ST_HALTED)};
            4'd9:    db_rdata = {13'h0, 1'b0, (state_q == ST_STEP), (state_q == ST_RUN)};
            4'd10:   db_rdata = step_ext;
            4'd11:   db_rdata = scratch_q;
            4'd12:   db_rdata = break_rd_s;
            default: db_rdata = 16'h0000;
        endcase
    end

    assign cpu_run       = cpu_run_q;
    assign cpu_reset_req = cpu_reset_req_q;

endmodule

// File: tb/tb_spy_regs.sv
// Directed self-checking bench for spy_regs (default parameters, RUN_ON_RESET=0).
module tb_spy_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dbread = 1'b0;
    logic        dbwrite = 1'b0;
    logic [3:0]  eadr = 4'd0;
    logic [15:0] db_wdata = 16'h0;
    logic [15:0] db_rdata;
    logic [47:0] cpu_ir = 48'h0;
    logic [13:0] cpu_pc = 14'h0;
    logic [31:0] cpu_md = 32'h0;
    logic [31:0] cpu_vma = 32'h0;
    logic        cpu_inst_done = 1'b0;
    logic        cpu_run;
    logic        cpu_reset_req;

    int tests_run = 0;
    int tests_failed = 0;

    spy_regs dut (
        .clk(clk), .reset(reset), .dbread(dbread), .dbwrite(dbwrite), .eadr(eadr),
        .db_wdata(db_wdata), .db_rdata(db_rdata), .cpu_ir(cpu_ir), .cpu_pc(cpu_pc),
        .cpu_md(cpu_md), .cpu_vma(cpu_vma), .cpu_inst_done(cpu_inst_done),
        .cpu_run(cpu_run), .cpu_reset_req(cpu_reset_req)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        eadr = a; db_wdata = d; dbwrite = 1'b1;
        @(negedge clk);
        dbwrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        eadr = a; dbread = 1'b1;
        #1;
        check_eq(tag, {16'h0, db_rdata}, {16'h0, exp});
        dbread = 1'b0;
    endtask

    task automatic pulse(input logic [13:0] pc);
        @(negedge clk);
        cpu_pc = pc; cpu_inst_done = 1'b1;
        @(negedge clk);
        cpu_inst_done = 1'b0;
    endtask

    initial begin
        do_reset();
        rd_chk("rst_status", 4'd8, 16'h0001);
        check_eq("rst_run", {31'h0, cpu_run}, 32'h0);
        check_eq("rst_rreq", {31'h0, cpu_reset_req}, 32'h0);
        rd_chk("rst_ctrl", 4'd9, 16'h0000);
        rd_chk("rst_pc", 4'd3, 16'h0000);

        // Run, request halt, halt lands on next boundary with its snapshot.
        wr(4'd9, 16'h0001);
        check_eq("run_en", {31'h0, cpu_run}, 32'h1);
        rd_chk("run_status", 4'd8, 16'h0000);
        rd_chk("run_ctrl", 4'd9, 16'h0001);
        wr(4'd9, 16'h0000);
        check_eq("halt_pend_run", {31'h0, cpu_run}, 32'h1);
        cpu_ir = 48'hA1B2_C3D4_E5F6; cpu_md = 32'h1234_5678; cpu_vma = 32'h9ABC_DEF0;
        pulse(14'h0123);
        rd_chk("halt_status", 4'd8, 16'h0001);
        check_eq("halt_run", {31'h0, cpu_run}, 32'h0);
        rd_chk("snap_pc", 4'd3, 16'h0123);
        rd_chk("snap_ir0", 4'd0, 16'hE5F6);
        rd_chk("snap_ir1", 4'd1, 16'hC3D4);
        rd_chk("snap_ir2", 4'd2, 16'hA1B2);
        rd_chk("snap_md0", 4'd4, 16'h5678);
        rd_chk("snap_md1", 4'd5, 16'h1234);
        rd_chk("snap_vma0", 4'd6, 16'hDEF0);
        rd_chk("snap_vma1", 4'd7, 16'h9ABC);
        pulse(14'h0456);
        rd_chk("frozen_pc", 4'd3, 16'h0123);

        // Three-instruction step with five boundaries offered.
        wr(4'd10, 16'h0003);
        wr(4'd11, 16'hBEEF);
        rd_chk("stepcnt_rd", 4'd10, 16'h0003);
        rd_chk("scratch_rd", 4'd11, 16'hBEEF);
        wr(4'd9, 16'h0002);
        rd_chk("step_status", 4'd8, 16'h0002);
        rd_chk("step_ctrl", 4'd9, 16'h0002);
        pulse(14'h0001);
        pulse(14'h0002);
        check_eq("step2_run", {31'h0, cpu_run}, 32'h1);
        pulse(14'h0003);
        check_eq("step3_run", {31'h0, cpu_run}, 32'h0);
        rd_chk("step3_status", 4'd8, 16'h0001);
        pulse(14'h0004);
        pulse(14'h0005);
        rd_chk("step_snaps", 4'd3, 16'h0003);

        // Zero step count behaves as one.
        wr(4'd10, 16'h0000);
        wr(4'd9, 16'h0002);
        rd_chk("step0_status", 4'd8, 16'h0002);
        pulse(14'h0010);
        rd_chk("step0_done", 4'd8, 16'h0001);
        rd_chk("step0_pc", 4'd3, 16'h0010);

        // Reset request pulse, state unchanged (while halted and while running).
        wr(4'd9, 16'h0004);
        check_eq("rreq_hi", {31'h0, cpu_reset_req}, 32'h1);
        @(negedge clk);
        check_eq("rreq_lo", {31'h0, cpu_reset_req}, 32'h0);
        rd_chk("rreq_status_h", 4'd8, 16'h0001);
        wr(4'd9, 16'h0001);
        wr(4'd9, 16'h0004);
        check_eq("rreq_hi2", {31'h0, cpu_reset_req}, 32'h1);
        rd_chk("rreq_status_r", 4'd8, 16'h0000);

        // Run and step together: run wins.
        wr(4'd9, 16'h0003);
        rd_chk("runstep_ctrl", 4'd9, 16'h0001);

        // CONTROL write beats a terminating boundary; snapshot still loads.
        wr(4'd10, 16'h0001);
        wr(4'd9, 16'h0002);
        @(negedge clk);
        eadr = 4'd9; db_wdata = 16'h0001; dbwrite = 1'b1;
        cpu_pc = 14'h0077; cpu_inst_done = 1'b1;
        @(negedge clk);
        dbwrite = 1'b0; cpu_inst_done = 1'b0;
        rd_chk("wrwin_ctrl", 4'd9, 16'h0001);
        check_eq("wrwin_run", {31'h0, cpu_run}, 32'h1);
        rd_chk("wrwin_pc", 4'd3, 16'h0077);

        // Reset in the middle of a step.
        wr(4'd10, 16'h0005);
        wr(4'd9, 16'h0002);
        pulse(14'h0020);
        do_reset();
        rd_chk("midrst_status", 4'd8, 16'h0001);
        check_eq("midrst_run", {31'h0, cpu_run}, 32'h0);
        rd_chk("midrst_stepcnt", 4'd10, 16'h0000);
        rd_chk("midrst_pc", 4'd3, 16'h0000);

        // Unmapped addresses.
        wr(4'd13, 16'hFFFF);
        rd_chk("adr13", 4'd13, 16'h0000);
        rd_chk("adr15", 4'd15, 16'h0000);

`ifdef SPY_BREAKPOINT_EN
        wr(4'd12, 16'h8050);
        rd_chk("brk_rd", 4'd12, 16'h8050);
        wr(4'd9, 16'h0001);
        pulse(14'h0040);
        check_eq("brk_miss", {31'h0, cpu_run}, 32'h1);
        pulse(14'h0050);
        rd_chk("brk_status", 4'd8, 16'h0005);
        check_eq("brk_run", {31'h0, cpu_run}, 32'h0);
        wr(4'd9, 16'h0000);
        rd_chk("brk_clear", 4'd8, 16'h0001);
`else
        wr(4'd12, 16'h8050);
        rd_chk("brk_absent", 4'd12, 16'h0000);
        wr(4'd9, 16'h0001);
        pulse(14'h0050);
        rd_chk("brk_nohalt", 4'd8, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
